// File: rtl/rv_insn_encoder_pkg.sv
// rv_insn_encoder_pkg: encoder op codes, RV64I opcode/funct constants, per-op format table and immediate range helper
package rv_insn_encoder_pkg;
  typedef enum logic [5:0] {
    BEQ, BNE, BLT, BGE, BLTU, BGEU, JALR, JAL, LUI, AUIPC,
    ADDI, SLLI, SLTI, SLTIU, XORI, SRLI, SRAI, ORI, ANDI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW, SRAW,
    LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
    FENCE, SCALL, SBREAK, SRET, WFI, MRTS
  } encoder_op_e;
  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SH64, FMT_SH32, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_SYS, FMT_BAD
  } fmt_e;
  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
  } op_info_t;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] F7_BASE      = 7'b0000000;
  localparam logic [6:0] F7_ALT       = 7'b0100000;
  localparam logic [31:0] NOP         = 32'h0000_0013;
  // True when v is representable as an n-bit two's-complement value.
  function automatic logic sfits(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = 32'($signed(v) >>> (n - 1));
    return t == '0 || &t;
  endfunction
  function automatic op_info_t op_info(input logic [5:0] op);
    case (op)
      BEQ:    return '{FMT_B, OPC_BRANCH, 3'd0, F7_BASE};
      BNE:    return '{FMT_B, OPC_BRANCH, 3'd1, F7_BASE};
      BLT:    return '{FMT_B, OPC_BRANCH, 3'd4, F7_BASE};
      BGE:    return '{FMT_B, OPC_BRANCH, 3'd5, F7_BASE};
      BLTU:   return '{FMT_B, OPC_BRANCH, 3'd6, F7_BASE};
      BGEU:   return '{FMT_B, OPC_BRANCH, 3'd7, F7_BASE};
      JALR:   return '{FMT_I, OPC_JALR, 3'd0, F7_BASE};
      JAL:    return '{FMT_J, OPC_JAL, 3'd0, F7_BASE};
      LUI:    return '{FMT_U, OPC_LUI, 3'd0, F7_BASE};
      AUIPC:  return '{FMT_U, OPC_AUIPC, 3'd0, F7_BASE};
      ADDI:   return '{FMT_I, OPC_OP_IMM, 3'd0, F7_BASE};
      SLLI:   return '{FMT_SH64, OPC_OP_IMM, 3'd1, F7_BASE};
      SLTI:   return '{FMT_I, OPC_OP_IMM, 3'd2, F7_BASE};
      SLTIU:  return '{FMT_I, OPC_OP_IMM, 3'd3, F7_BASE};
      XORI:   return '{FMT_I, OPC_OP_IMM, 3'd4, F7_BASE};
      SRLI:   return '{FMT_SH64, OPC_OP_IMM, 3'd5, F7_BASE};
      SRAI:   return '{FMT_SH64, OPC_OP_IMM, 3'd5, F7_ALT};
      ORI:    return '{FMT_I, OPC_OP_IMM, 3'd6, F7_BASE};
      ANDI:   return '{FMT_I, OPC_OP_IMM, 3'd7, F7_BASE};
      ADD:    return '{FMT_R, OPC_OP, 3'd0, F7_BASE};
      SUB:    return '{FMT_R, OPC_OP, 3'd0, F7_ALT};
      SLL:    return '{FMT_R, OPC_OP, 3'd1, F7_BASE};
      SLT:    return '{FMT_R, OPC_OP, 3'd2, F7_BASE};
      SLTU:   return '{FMT_R, OPC_OP, 3'd3, F7_BASE};
      XOR:    return '{FMT_R, OPC_OP, 3'd4, F7_BASE};
      SRL:    return '{FMT_R, OPC_OP, 3'd5, F7_BASE};
      SRA:    return '{FMT_R, OPC_OP, 3'd5, F7_ALT};
      OR:     return '{FMT_R, OPC_OP, 3'd6, F7_BASE};
      AND:    return '{FMT_R, OPC_OP, 3'd7, F7_BASE};
      ADDIW:  return '{FMT_I, OPC_OP_IMM32, 3'd0, F7_BASE};
      SLLIW:  return '{FMT_SH32, OPC_OP_IMM32, 3'd1, F7_BASE};
      SRLIW:  return '{FMT_SH32, OPC_OP_IMM32, 3'd5, F7_BASE};
      SRAIW:  return '{FMT_SH32, OPC_OP_IMM32, 3'd5, F7_ALT};
      ADDW:   return '{FMT_R, OPC_OP32, 3'd0, F7_BASE};
      SUBW:   return '{FMT_R, OPC_OP32, 3'd0, F7_ALT};
      SLLW:   return '{FMT_R, OPC_OP32, 3'd1, F7_BASE};
      SRLW:   return '{FMT_R, OPC_OP32, 3'd5, F7_BASE};
      SRAW:   return '{FMT_R, OPC_OP32, 3'd5, F7_ALT};
      LB:     return '{FMT_I, OPC_LOAD, 3'd0, F7_BASE};
      LH:     return '{FMT_I, OPC_LOAD, 3'd1, F7_BASE};
      LW:     return '{FMT_I, OPC_LOAD, 3'd2, F7_BASE};
      LD:     return '{FMT_I, OPC_LOAD, 3'd3, F7_BASE};
      LBU:    return '{FMT_I, OPC_LOAD, 3'd4, F7_BASE};
      LHU:    return '{FMT_I, OPC_LOAD, 3'd5, F7_BASE};
      LWU:    return '{FMT_I, OPC_LOAD, 3'd6, F7_BASE};
      SB:     return '{FMT_S, OPC_STORE, 3'd0, F7_BASE};
      SH:     return '{FMT_S, OPC_STORE, 3'd1, F7_BASE};
      SW:     return '{FMT_S, OPC_STORE, 3'd2, F7_BASE};
      SD:     return '{FMT_S, OPC_STORE, 3'd3, F7_BASE};
      CSRRW:  return '{FMT_CSR, OPC_SYSTEM, 3'd1, F7_BASE};
      CSRRS:  return '{FMT_CSR, OPC_SYSTEM, 3'd2, F7_BASE};
      CSRRC:  return '{FMT_CSR, OPC_SYSTEM, 3'd3, F7_BASE};
      CSRRWI: return '{FMT_CSR, OPC_SYSTEM, 3'd5, F7_BASE};
      CSRRSI: return '{FMT_CSR, OPC_SYSTEM, 3'd6, F7_BASE};
      CSRRCI: return '{FMT_CSR, OPC_SYSTEM, 3'd7, F7_BASE};
      FENCE:  return '{FMT_I, OPC_MISC_MEM, 3'd0, F7_BASE};
      SCALL, SBREAK, SRET, WFI, MRTS: return '{FMT_SYS, OPC_SYSTEM, 3'd0, F7_BASE};
      default: return '{FMT_BAD, OPC_OP_IMM, 3'd0, F7_BASE};
    endcase
  endfunction
endpackage

// File: rtl/rv_insn_pack.sv
// rv_insn_pack: combinational (op, rd, rs1, rs2, imm) -> {insn, err}; illegal tuples become NOP with err
module rv_insn_pack
  import rv_insn_encoder_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] insn,
  output logic        err
);
  op_info_t    info;
  logic [31:0] word;
  logic [31:0] i_w;
  logic [11:0] sys_f12;
  logic        ok;
  assign info = op_info(op);
  assign i_w = {imm[11:0], rs1, info.f3, rd, info.opc};
  assign sys_f12 = op == SCALL  ? 12'h000 :
                   op == SBREAK ? 12'h001 :
                   op == SRET   ? 12'h100 :
                   op == WFI    ? 12'h102 : 12'h305;
  always_comb begin
    word = i_w;
    ok = 1'b1;
    case (info.fmt)
      FMT_R:    word = {info.f7, rs2, rs1, info.f3, rd, info.opc};
      FMT_I:    ok = sfits(imm, 12);
      FMT_SH64: begin
        word = {info.f7[6:1], imm[5:0], rs1, info.f3, rd, info.opc};
        ok = imm[31:6] == '0;
      end
      FMT_SH32: begin
        word = {info.f7, imm[4:0], rs1, info.f3, rd, info.opc};
        ok = imm[31:5] == '0;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, info.f3, imm[4:0], info.opc};
        ok = sfits(imm, 12);
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, info.f3, imm[4:1], imm[11], info.opc};
        ok = !imm[0] && sfits(imm, 13);
      end
      FMT_U: begin
        word = {imm[31:12], rd, info.opc};
        ok = imm[11:0] == '0;
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, info.opc};
        ok = !imm[0] && sfits(imm, 21);
      end
      FMT_CSR:  ok = imm[31:12] == '0;
      FMT_SYS:  word = {sys_f12, 13'd0, OPC_SYSTEM};
      default:  ok = 1'b0;
    endcase
  end
  assign err = !ok;
  assign insn = ok ? word : NOP;
endmodule

// File: rtl/rv_insn_encoder.sv
// rv_insn_encoder: two-stage valid/ready RV64I encoder; tuples in, address-tagged 32-bit words out, saturating error count
module rv_insn_encoder
  import rv_insn_encoder_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_op,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_insn,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_err,
  input  logic                 addr_load,
  input  logic [ADDR_W-1:0]    addr_base,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  logic        s1_valid;
  logic [5:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [31:0] s1_imm;
  logic [31:0] pk_insn;
  logic        pk_err;
  logic        s2_ready;
  logic        hs;
  logic        unused_base;
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !reset && (!s1_valid || s2_ready);
  assign hs = out_valid && out_ready;
  assign unused_base = ^addr_base[1:0];
  rv_insn_pack u_pack (
    .op   (s1_op),
    .rd   (s1_rd),
    .rs1  (s1_rs1),
    .rs2  (s1_rs2),
    .imm  (s1_imm),
    .insn (pk_insn),
    .err  (pk_err)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      out_insn <= '0;
      out_err <= 1'b0;
      out_addr <= RESET_ADDR;
      err_cnt <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        s1_op <= in_op;
        s1_rd <= in_rd;
        s1_rs1 <= in_rs1;
        s1_rs2 <= in_rs2;
        s1_imm <= in_imm;
      end
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_insn <= pk_insn;
          out_err <= pk_err;
        end
      end
      // a load wins over the increment; the word leaving this cycle already shows its address
      out_addr <= addr_load ? {addr_base[ADDR_W-1:2], 2'b00} : hs ? out_addr + ADDR_W'(4) : out_addr;
      if (hs && out_err && !(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_rv_insn_encoder.sv
// tb_rv_insn_encoder: directed self-checking bench for rv_insn_encoder
module tb_rv_insn_encoder;
  import rv_insn_encoder_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_insn;
  logic [31:0] out_addr;
  logic        out_err;
  logic        addr_load = 1'b0;
  logic [31:0] addr_base = '0;
  logic [7:0]  err_cnt;
  int passed = 0;
  int fails = 0;
  int total = 0;
  int cyc = 0;
  logic [31:0] q_insn[$];
  logic [31:0] q_addr[$];
  logic        q_err[$];
  int          q_cyc[$];
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, insn;
    logic        err;
  } vec_t;
  vec_t vq[$];
  rv_insn_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_addr(out_addr),
    .out_err(out_err), .addr_load(addr_load), .addr_base(addr_base), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      q_insn.push_back(out_insn);
      q_addr.push_back(out_addr);
      q_err.push_back(out_err);
      q_cyc.push_back(cyc);
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic put(input logic [5:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
    if (!in_ready) begin
      total++;
      fails++;
      $error("FAIL put_timeout: in_ready observed 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic load(input logic [31:0] b);
    addr_base = b;
    addr_load = 1'b1;
    tick();
    addr_load = 1'b0;
  endtask
  task automatic clear_q;
    q_insn.delete(); q_addr.delete(); q_err.delete(); q_cyc.delete();
  endtask
  task automatic add(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                     input logic [31:0] imm, insn, input logic err);
    vq.push_back('{op, rd, rs1, rs2, imm, insn, err});
  endtask
  task automatic run(input string name, input logic [31:0] base);
    load(base);
    clear_q();
    foreach (vq[i]) put(vq[i].op, vq[i].rd, vq[i].rs1, vq[i].rs2, vq[i].imm);
    repeat (4) tick();
    chk($sformatf("%s_count", name), 64'(q_insn.size()), 64'(vq.size()));
    for (int i = 0; i < vq.size() && i < q_insn.size(); i++) begin
      chk($sformatf("%s_insn%0d", name, i), 64'(q_insn[i]), 64'(vq[i].insn));
      chk($sformatf("%s_err%0d", name, i), 64'(q_err[i]), 64'(vq[i].err));
      chk($sformatf("%s_addr%0d", name, i), 64'(q_addr[i]), 64'(base + 32'(4 * i)));
      chk($sformatf("%s_gap%0d", name, i), 64'(q_cyc[i] - q_cyc[0]), 64'(i));
    end
    vq.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_insn", 64'(out_insn), 0);
    chk("rst_out_err", 64'(out_err), 0);
    chk("rst_err_cnt", 64'(err_cnt), 0);
    chk("rst_out_addr", 64'(out_addr), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 1);
    put(ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("lat_not_1", 64'(out_valid), 0);
    tick();
    chk("lat_valid", 64'(out_valid), 1);
    chk("addi_insn", 64'(out_insn), 64'h0050_0093);
    chk("addi_err", 64'(out_err), 0);
    chk("addi_addr", 64'(out_addr), 0);
    tick();
    add(ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    add(BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 1'b0);
    add(JAL, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF, 1'b0);
    add(LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    run("stream", 32'h0);
    add(ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, NOP, 1'b1);
    add(BEQ, 5'd0, 5'd1, 5'd2, 32'd3, NOP, 1'b1);
    run("errA", 32'h1000);
    chk("err_cnt_2", 64'(err_cnt), 2);
    add(ADDI, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0);
    add(BEQ, 5'd0, 5'd0, 5'd0, 32'd4094, 32'h7E00_0FE3, 1'b0);
    add(SLLI, 5'd1, 5'd1, 5'd0, 32'd63, 32'h03F0_9093, 1'b0);
    add(SRAI, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030_D093, 1'b0);
    add(SD, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_BC23, 1'b0);
    add(SLLIW, 5'd1, 5'd1, 5'd0, 32'd32, NOP, 1'b1);
    add(LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5001, NOP, 1'b1);
    add(6'd62, 5'd1, 5'd1, 5'd1, 32'd0, NOP, 1'b1);
    add(CSRRW, 5'd1, 5'd2, 5'd0, 32'h300, 32'h3001_10F3, 1'b0);
    add(CSRRW, 5'd1, 5'd2, 5'd0, 32'd4096, NOP, 1'b1);
    add(SCALL, 5'd7, 5'd7, 5'd7, 32'h123, 32'h0000_0073, 1'b0);
    run("errB", 32'h2000);
    chk("err_cnt_6", 64'(err_cnt), 6);
    load(32'h40);
    clear_q();
    out_ready = 1'b0;
    put(ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
    put(ADDI, 5'd2, 5'd0, 5'd0, 32'd2);
    chk("bp_in_ready_drop", 64'(in_ready), 0);
    in_op = ADDI; in_rd = 5'd3; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_insn_hold%0d", i), 64'(out_insn), 64'h0010_0093);
      chk($sformatf("bp_addr_hold%0d", i), 64'(out_addr), 64'h40);
      chk($sformatf("bp_in_ready%0d", i), 64'(in_ready), 0);
    end
    out_ready = 1'b1;
    put(ADDI, 5'd3, 5'd0, 5'd0, 32'd3);
    put(ADDI, 5'd4, 5'd0, 5'd0, 32'd4);
    repeat (4) tick();
    chk("bp_count", 64'(q_insn.size()), 4);
    if (q_insn.size() == 4) begin
      chk("bp_w0", 64'(q_insn[0]), 64'h0010_0093);
      chk("bp_w1", 64'(q_insn[1]), 64'h0020_0113);
      chk("bp_w2", 64'(q_insn[2]), 64'h0030_0193);
      chk("bp_w3", 64'(q_insn[3]), 64'h0040_0213);
      chk("bp_a3", 64'(q_addr[3]), 64'h4C);
      chk("bp_gap", 64'(q_cyc[3] - q_cyc[0]), 3);
    end
    load(32'hFFFF_FFFF);
    clear_q();
    put(ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
    put(ADDI, 5'd2, 5'd0, 5'd0, 32'd2);
    repeat (4) tick();
    chk("wrap_count", 64'(q_addr.size()), 2);
    if (q_addr.size() == 2) begin
      chk("wrap_a0", 64'(q_addr[0]), 64'hFFFF_FFFC);
      chk("wrap_a1", 64'(q_addr[1]), 64'h0);
    end
    clear_q();
    out_ready = 1'b0;
    put(ADDI, 5'd5, 5'd0, 5'd0, 32'd5);
    tick();
    addr_base = 32'h200;
    addr_load = 1'b1;
    out_ready = 1'b1;
    tick();
    addr_load = 1'b0;
    put(ADDI, 5'd6, 5'd0, 5'd0, 32'd6);
    repeat (4) tick();
    chk("ld_hs_count", 64'(q_addr.size()), 2);
    if (q_addr.size() == 2) begin
      chk("ld_hs_old_addr", 64'(q_addr[0]), 64'h4);
      chk("ld_hs_new_addr", 64'(q_addr[1]), 64'h200);
    end
    out_ready = 1'b0;
    put(ADDI, 5'd1, 5'd0, 5'd0, 32'd4096);
    put(ADDI, 5'd2, 5'd0, 5'd0, 32'd2);
    reset = 1'b1;
    tick();
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_err_cnt", 64'(err_cnt), 0);
    chk("mid_rst_addr", 64'(out_addr), 0);
    chk("mid_rst_in_ready", 64'(in_ready), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    clear_q();
    put(ADDI, 5'd7, 5'd0, 5'd0, 32'd7);
    repeat (4) tick();
    chk("after_rst_count", 64'(q_insn.size()), 1);
    if (q_insn.size() == 1) begin
      chk("after_rst_insn", 64'(q_insn[0]), 64'h0070_0393);
      chk("after_rst_addr", 64'(q_addr[0]), 64'h0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
